// File: rtl/nios_cpu_cpu_mult_seq.sv
// Iterative limb-by-limb multiplier with signed/unsigned operands, valid/ready handshakes and kill.
// Optional build macro MULT_SEQ_ZERO_SKIP_EN: zero operands bypass CALC and go straight to FIX.
module nios_cpu_cpu_mult_seq #(
    parameter int DATA_W = 32,
    parameter int LIMB_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic              signed_a,
    input  logic              signed_b,
    input  logic              kill,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result_lo,
    output logic [DATA_W-1:0] result_hi,
    output logic              busy
);
    localparam int NLIMB = DATA_W / LIMB_W;
    localparam int NSTEP = NLIMB * NLIMB;
    localparam int CNT_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam int P_W   = 2 * DATA_W;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state_q, state_d;
    logic [DATA_W:0]   mag_a_q, mag_a_d;
    logic [DATA_W:0]   mag_b_q, mag_b_d;
    logic              neg_q, neg_d;
    logic [P_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [P_W-1:0]    res_q, res_d;

    logic [LIMB_W-1:0]   limb_a, limb_b;
    logic [2*LIMB_W-1:0] prod;
    logic [P_W-1:0]      term, fold;
    logic                last;
    int                  li, lj;

    // Limb selection and the partial product for the current step.
    always_comb begin
        li     = int'(cnt_q) / NLIMB;
        lj     = int'(cnt_q) % NLIMB;
        limb_a = '0;
        limb_b = '0;
        for (int n = 0; n < NLIMB; n++) begin
            if (li == n) limb_a = mag_a_q[n*LIMB_W +: LIMB_W];
            if (lj == n) limb_b = mag_b_q[n*LIMB_W +: LIMB_W];
        end
        prod = {{LIMB_W{1'b0}}, limb_a} * {{LIMB_W{1'b0}}, limb_b};
        term = P_W'(prod) << ((li + lj) * LIMB_W);
        last = (cnt_q == CNT_W'(NSTEP - 1));
        // Magnitude bit DATA_W: a*2^W*B covers the (2^W)^2 cross term, b*2^W*A' the rest.
        fold = '0;
        if (last && mag_a_q[DATA_W]) fold = fold + (P_W'(mag_b_q) << DATA_W);
        if (last && mag_b_q[DATA_W]) fold = fold + (P_W'(mag_a_q[DATA_W-1:0]) << DATA_W);
    end

    always_comb begin
        state_d = state_q;
        mag_a_d = mag_a_q;
        mag_b_d = mag_b_q;
        neg_d   = neg_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (in_valid && !kill) begin
                    mag_a_d = (signed_a && src_a[DATA_W-1]) ? ('0 - {1'b1, src_a}) : {1'b0, src_a};
                    mag_b_d = (signed_b && src_b[DATA_W-1]) ? ('0 - {1'b1, src_b}) : {1'b0, src_b};
                    neg_d   = (signed_a & src_a[DATA_W-1]) ^ (signed_b & src_b[DATA_W-1]);
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = CALC;
`ifdef MULT_SEQ_ZERO_SKIP_EN
                    if (src_a == '0 || src_b == '0) begin
                        neg_d   = 1'b0;
                        state_d = FIX;
                    end
`endif
                end
            end
            CALC: begin
                acc_d = acc_q + term + fold;
                cnt_d = cnt_q + 1'b1;
                if (last) state_d = FIX;
            end
            FIX: begin
                res_d   = neg_q ? ('0 - acc_q) : acc_q;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Flush wins over everything, including a pending result handoff.
        if (kill) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            mag_a_q <= '0;
            mag_b_q <= '0;
            neg_q   <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            mag_a_q <= mag_a_d;
            mag_b_q <= mag_b_d;
            neg_q   <= neg_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign result_lo = res_q[DATA_W-1:0];
    assign result_hi = res_q[P_W-1:DATA_W];
endmodule

// File: tb/tb_nios_cpu_cpu_mult_seq.sv
// Directed-vector bench for nios_cpu_cpu_mult_seq (default 32-bit data, 16-bit limbs).
module tb_nios_cpu_cpu_mult_seq;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready;
    logic [31:0] src_a, src_b;
    logic        signed_a, signed_b;
    logic        kill;
    logic        out_valid, out_ready;
    logic [31:0] result_lo, result_hi;
    logic        busy;

    int errors = 0;
    int checks = 0;

    nios_cpu_cpu_mult_seq #(.DATA_W(32), .LIMB_W(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .src_a(src_a), .src_b(src_b),
        .signed_a(signed_a), .signed_b(signed_b),
        .kill(kill),
        .out_valid(out_valid), .out_ready(out_ready),
        .result_lo(result_lo), .result_hi(result_hi),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one op, wait for out_valid, check latency and product; optionally accept it.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sa, input logic sb, input logic [63:0] exp_p,
                          input int exp_lat, input logic ack);
        int lat;
        @(negedge clk);
        src_a = a; src_b = b; signed_a = sa; signed_b = sb; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".valid"}, {63'd0, out_valid}, 64'd1);
        if (exp_lat > 0) check({tag, ".lat"}, 64'(lat), 64'(exp_lat));
        check({tag, ".prod"}, {result_hi, result_lo}, exp_p);
        check({tag, ".in_ready"}, {63'd0, in_ready}, 64'd0);
        $display("op %s: a=%h b=%h sa=%0d sb=%0d -> %h_%h lat=%0d", tag, a, b, sa, sb,
                 result_hi, result_lo, lat);
        if (ack) begin
            @(negedge clk); out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            check({tag, ".idle"}, {62'd0, in_ready, out_valid}, 64'd2);
        end
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; kill = 1'b0; out_ready = 1'b0;
        src_a = '0; src_b = '0; signed_a = 1'b0; signed_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.ctrl", {61'd0, in_ready, out_valid, busy}, 64'd4);
        check("rst.res", {result_hi, result_lo}, 64'd0);
        @(negedge clk); reset_n = 1'b1;

        run_op("uu_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 64'hFFFFFFFE_00000001, 5, 1'b1);
        run_op("ss_m1",  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 64'h00000000_00000001, 5, 1'b1);
        run_op("su_m1",  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 64'hFFFFFFFF_00000001, 5, 1'b1);
        run_op("ss_min", 32'h80000000, 32'h80000000, 1'b1, 1'b1, 64'h40000000_00000000, 5, 1'b1);
        run_op("ss_neg", 32'hFFFFFFFD, 32'h00000007, 1'b1, 1'b1, 64'hFFFFFFFF_FFFFFFEB, 5, 1'b1);
        run_op("uu_limb", 32'h00010000, 32'h00010000, 1'b0, 1'b0, 64'h00000001_00000000, 5, 1'b1);
        run_op("su_min", 32'h80000000, 32'h00000002, 1'b1, 1'b0, 64'hFFFFFFFF_00000000, 5, 1'b1);

        // Backpressure: result must hold while out_ready stays low.
        run_op("bp", 32'h00000003, 32'h00000005, 1'b0, 1'b0, 64'd15, 5, 1'b0);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (c % 3 == 2) begin
                check("bp.hold_valid", {62'd0, out_valid, in_ready}, 64'd2);
                check("bp.hold_res", {result_hi, result_lo}, 64'd15);
            end
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp.release", {61'd0, in_ready, out_valid, busy}, 64'd4);

        // Kill during the second CALC cycle.
        @(negedge clk);
        src_a = 32'd5; src_b = 32'd9; signed_a = 1'b0; signed_b = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill.busy", {62'd0, busy, out_valid}, 64'd0);
        begin
            logic seen;
            seen = 1'b0;
            for (int c = 0; c < 8; c++) begin
                @(posedge clk); #1;
                seen = seen | out_valid;
            end
            check("kill.no_valid", {63'd0, seen}, 64'd0);
        end
        check("kill.res_hold", {result_hi, result_lo}, 64'd15);
        run_op("after_kill", 32'd3, 32'd7, 1'b0, 1'b0, 64'd21, 5, 1'b1);

        // Kill in IDLE with in_valid must not capture.
        @(negedge clk);
        src_a = 32'd2; src_b = 32'd2; in_valid = 1'b1; kill = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; kill = 1'b0;
        check("kill_idle", {62'd0, busy, in_ready}, 64'd1);

        // Kill beats out_ready in DONE.
        run_op("kdone", 32'd6, 32'd6, 1'b0, 1'b0, 64'd36, 5, 1'b0);
        @(negedge clk); out_ready = 1'b1; kill = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; kill = 1'b0;
        check("kdone.idle", {61'd0, in_ready, out_valid, busy}, 64'd4);
        check("kdone.res", {result_hi, result_lo}, 64'd36);

`ifdef MULT_SEQ_ZERO_SKIP_EN
        run_op("zero", 32'h00000000, 32'h00001234, 1'b0, 1'b0, 64'd0, 0, 1'b1);
`else
        run_op("zero", 32'h00000000, 32'h00001234, 1'b0, 1'b0, 64'd0, 5, 1'b1);
`endif

        // Reset mid-operation returns everything to reset values.
        @(negedge clk);
        src_a = 32'd9; src_b = 32'd9; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check("rst_mid.ctrl", {61'd0, in_ready, out_valid, busy}, 64'd4);
        check("rst_mid.res", {result_hi, result_lo}, 64'd0);
        @(negedge clk); reset_n = 1'b1;
        run_op("post_rst", 32'd11, 32'd13, 1'b0, 1'b0, 64'd143, 5, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
